// File: rtl/kes_cpu_pkg.sv
// kes_cpu_pkg: shared state encoding and instruction-field helpers for kes_subneg_cpu.
// Field layout (low to high): target | src2 | src1 | dest, each AW bits wide.
package kes_cpu_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, RD_S1, RD_S2, EXEC, WR_D, HALT} state_t;
  function automatic int dest_lsb(input int aw);
    return 3 * aw;
  endfunction
  function automatic int src1_lsb(input int aw);
    return 2 * aw;
  endfunction
  function automatic int src2_lsb(input int aw);
    return aw;
  endfunction
  // All four address fields must fit inside one data word.
  function automatic bit fields_fit(input int dw, input int aw);
    return dw >= 4 * aw;
  endfunction
endpackage

// File: rtl/kes_mem_req.sv
// kes_mem_req: one-outstanding start/done handshake sequencer.
// Ports: req_i pulse launches an access with addr_i/wdata_i/write_i, which are
// registered onto mem_*_o and held until mem_done_i; ack_o flags the completing
// cycle and rdata_o carries the read word valid alongside ack_o.
module kes_mem_req #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          write_i,
  input  logic          mem_done_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          mem_start_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          ack_o,
  output logic [DW-1:0] rdata_o
);
  logic          start_q, start_d, write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  // done outside an active request is ignored
  assign ack_o   = start_q & mem_done_i;
  assign rdata_o = mem_rdata_i;
  always_comb begin
    start_d = req_i ? 1'b1 : (ack_o ? 1'b0 : start_q);
    addr_d  = req_i ? addr_i : addr_q;
    wdata_d = req_i ? wdata_i : wdata_q;
    write_d = req_i ? write_i : write_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      start_q <= start_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_start_o = start_q;
  assign mem_write_o = write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: rtl/kes_subneg_cpu.sv
// kes_subneg_cpu: subtract-and-branch-if-negative CPU on a start/done word memory.
// Ports: clock/reset_n (async active-low), run gates new instructions; mem_*
// is the memory handshake; pc/ir/halted/retired expose architectural state.
module kes_subneg_cpu
  import kes_cpu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 8,
  parameter int HALT_PC    = 2**AW - 1,
  parameter bit BRANCH_LEQ = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             mem_write,
  output logic             mem_start,
  input  logic             mem_done,
  output logic [AW-1:0]    pc,
  output logic [DW-1:0]    ir,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  if (!fields_fit(DW, AW)) begin : g_bad_widths
    $error("kes_subneg_cpu: DW must be at least 4*AW");
  end
  localparam logic [AW-1:0] HALT_ADDR = AW'(HALT_PC);
  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, req_addr, dest, src1, src2, target;
  logic [DW-1:0]    ir_q, s1_q, s2_q, d_q, rdata;
  logic [CNT_W-1:0] retired_q;
  logic             req, ack, take, req_write;
  assign dest   = ir_q[dest_lsb(AW) +: AW];
  assign src1   = ir_q[src1_lsb(AW) +: AW];
  assign src2   = ir_q[src2_lsb(AW) +: AW];
  assign target = ir_q[AW-1:0];
  // d_q is written in EXEC, so during WR_D it is always this instruction's result
  assign take      = d_q[DW-1] | (BRANCH_LEQ & ~|d_q);
  assign req_addr  = state_q == RD_S1 ? src1 : state_q == RD_S2 ? src2 : state_q == WR_D ? dest : pc_q;
  assign req_write = state_q == WR_D;
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = pc_q == HALT_ADDR ? HALT : (run && !mem_done) ? FETCH : IDLE;
        req     = pc_q != HALT_ADDR && run && !mem_done;
      end
      // a follow-on access launches only once done has been seen low again
      FETCH, RD_S1, RD_S2, WR_D: begin
        req     = !mem_start && !mem_done;
        state_d = !ack ? state_q : state_q == FETCH ? RD_S1 : state_q == RD_S1 ? RD_S2 :
                  state_q == RD_S2 ? EXEC : IDLE;
      end
      EXEC:    state_d = WR_D;
      default: state_d = state_q;
    endcase
  end
  kes_mem_req #(.DW(DW), .AW(AW)) u_req (
    .clk_i(clock), .rst_ni(reset_n), .req_i(req), .addr_i(req_addr), .wdata_i(d_q),
    .write_i(req_write), .mem_done_i(mem_done), .mem_rdata_i(mem_rdata),
    .mem_start_o(mem_start), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .ack_o(ack), .rdata_o(rdata)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      d_q       <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ack && state_q == FETCH) begin
        ir_q <= rdata;
        pc_q <= pc_q + AW'(1);
      end
      if (ack && state_q == RD_S1) s1_q <= rdata;
      if (ack && state_q == RD_S2) s2_q <= rdata;
      if (state_q == EXEC) d_q <= s1_q - s2_q;
      if (ack && state_q == WR_D) begin
        if (take) pc_q <= target;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign halted  = state_q == HALT;
  assign retired = retired_q;
endmodule

// File: tb/tb_kes_subneg_cpu.sv
// tb_kes_subneg_cpu: four cores (default, HALT_PC=0, HALT_PC=200, BRANCH_LEQ=1) each on its own memory model.
module tb_kes_subneg_cpu;
  localparam int NI = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rn[NI], run[NI], mstart[NI], mwr[NI], mdone[NI], halted[NI];
  logic [7:0]  maddr[NI], pc[NI];
  logic [31:0] mwdata[NI], mrdata[NI], ir[NI];
  logic [15:0] retired[NI];
  logic [31:0] mem[NI][256];
  logic [39:0] exp_q[NI][$];
  int lmin[NI], lmax[NI], hold[NI], cnt[NI], hc[NI], nstart[NI];
  int errors = 0, checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic        sp = 1'b0, dp = 1'b0;
    logic [40:0] ap = '0;
    logic [39:0] e;
    kes_subneg_cpu #(.HALT_PC(g == 1 ? 0 : g == 2 ? 200 : 255), .BRANCH_LEQ(g == 3)) dut (
      .clock(clk), .reset_n(rn[g]), .run(run[g]), .mem_addr(maddr[g]), .mem_wdata(mwdata[g]),
      .mem_rdata(mrdata[g]), .mem_write(mwr[g]), .mem_start(mstart[g]), .mem_done(mdone[g]),
      .pc(pc[g]), .ir(ir[g]), .halted(halted[g]), .retired(retired[g])
    );
    always @(posedge clk) begin
      if (!rn[g]) begin
        mdone[g] <= 1'b0;
        cnt[g] = -1;
        hc[g] = 0;
      end else if (hc[g] > 0) begin
        hc[g]--;
        if (hc[g] == 0) mdone[g] <= 1'b0;
      end else if (mstart[g]) begin
        if (cnt[g] < 0) cnt[g] = int'($urandom_range(lmax[g], lmin[g])) - 1;
        if (cnt[g] == 0) begin
          if (mwr[g]) begin
            mem[g][maddr[g]] = mwdata[g];
            checks++;
            if (exp_q[g].size() == 0) begin
              errors++;
              $display("FAIL unexpected_write[%0d] addr=%0d data=%h required no write", g, maddr[g], mwdata[g]);
            end else begin
              e = exp_q[g].pop_front();
              if ({maddr[g], mwdata[g]} !== e) begin
                errors++;
                $display("FAIL write[%0d] got addr=%0d data=%h required addr=%0d data=%h", g, maddr[g], mwdata[g], e[39:32], e[31:0]);
              end
            end
          end else mrdata[g] <= mem[g][maddr[g]];
          mdone[g] <= 1'b1;
          hc[g] = hold[g];
          cnt[g] = -1;
        end else cnt[g]--;
      end
    end
    always @(negedge clk) begin
      if (mstart[g] && !sp) begin
        nstart[g]++;
        checks++;
        if (dp !== 1'b0) begin
          errors++;
          $display("FAIL reissue_while_done[%0d] done=%b required 0", g, dp);
        end
      end else if (mstart[g] && sp) begin
        checks++;
        if ({mwr[g], maddr[g], mwdata[g]} !== ap) begin
          errors++;
          $display("FAIL req_stable[%0d] got %h required %h", g, {mwr[g], maddr[g], mwdata[g]}, ap);
        end
      end
      sp = mstart[g];
      dp = mdone[g];
      ap = {mwr[g], maddr[g], mwdata[g]};
    end
  end

  task automatic clear_mem(input int k);
    for (int i = 0; i < 256; i++) mem[k][i] = '0;
  endtask

  task automatic set_lat(input int k, input int mn, input int mx, input int h);
    lmin[k] = mn;
    lmax[k] = mx;
    hold[k] = h;
  endtask

  task automatic reset_core(input int k);
    @(negedge clk);
    rn[k] = 1'b0;
    repeat (3) @(negedge clk);
    rn[k] = 1'b1;
  endtask

  task automatic run_prog(input int k, input int n, output bit to);
    run[k] = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (retired[k] == 16'(n) || halted[k]) begin
        to = 1'b0;
        break;
      end
    end
    run[k] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ISA-level reference: pushes each expected write and returns the final pc/count
  task automatic ref_exec(input int k, input int n, input bit leq, input int hp, output logic [7:0] epc, output int ecnt);
    logic [31:0] m[256];
    logic [31:0] w, d;
    for (int i = 0; i < 256; i++) m[i] = mem[k][i];
    epc = '0;
    ecnt = 0;
    while (ecnt < n && int'(epc) != hp) begin
      w = m[epc];
      epc = epc + 8'd1;
      d = m[w[23:16]] - m[w[15:8]];
      exp_q[k].push_back({w[31:24], d});
      m[w[31:24]] = d;
      if (d[31] || (leq && d == 0)) epc = w[7:0];
      ecnt++;
    end
  endtask

  task automatic test_reset();
    bit seen;
    clear_mem(0);
    mem[0][0] = 32'h0C0A0B05;
    set_lat(0, 5, 5, 1);
    reset_core(0);
    run[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = mstart[0];
    end
    @(negedge clk);
    rn[0] = 1'b0;
    #1;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_fetch_seen got %b required 1", seen); end
    checks++; if (mstart[0] !== 1'b0) begin errors++; $display("FAIL rst_start_drop got %b required 0", mstart[0]); end
    repeat (3) @(negedge clk);
    checks++; if (pc[0] !== 8'd0) begin errors++; $display("FAIL rst_pc got %0d required 0", pc[0]); end
    checks++; if (retired[0] !== 16'd0) begin errors++; $display("FAIL rst_retired got %0d required 0", retired[0]); end
    checks++; if (ir[0] !== 32'd0) begin errors++; $display("FAIL rst_ir got %h required 0", ir[0]); end
    checks++; if (halted[0] !== 1'b0) begin errors++; $display("FAIL rst_halted got %b required 0", halted[0]); end
    checks++; if ({mwr[0], maddr[0], mwdata[0]} !== 41'd0) begin errors++; $display("FAIL rst_mem_regs got %h required 0", {mwr[0], maddr[0], mwdata[0]}); end
    run[0] = 1'b0;
    rn[0] = 1'b1;
  endtask

  task automatic test_halt();
    int n0;
    set_lat(1, 1, 1, 1);
    reset_core(1);
    n0 = nstart[1];
    run[1] = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (halted[1] !== 1'b1) begin errors++; $display("FAIL halt_flag got %b required 1", halted[1]); end
    checks++; if (nstart[1] != n0 || mstart[1] !== 1'b0) begin errors++; $display("FAIL halt_no_start got %0d starts required 0", nstart[1] - n0); end
    checks++; if (pc[1] !== 8'd0) begin errors++; $display("FAIL halt_pc got %0d required 0", pc[1]); end
    run[1] = 1'b0;
  endtask

  task automatic test_nonbranch();
    bit to;
    clear_mem(0);
    mem[0][0] = 32'h0C0A0B05;
    mem[0][10] = 32'd7;
    mem[0][11] = 32'd3;
    set_lat(0, 1, 1, 1);
    reset_core(0);
    exp_q[0].push_back({8'd12, 32'd4});
    run_prog(0, 1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nb_timeout got %b required 0", to); end
    checks++; if (mem[0][12] !== 32'd4) begin errors++; $display("FAIL nb_mem12 got %h required 4", mem[0][12]); end
    checks++; if (pc[0] !== 8'd1) begin errors++; $display("FAIL nb_pc got %0d required 1", pc[0]); end
    checks++; if (retired[0] !== 16'd1) begin errors++; $display("FAIL nb_retired got %0d required 1", retired[0]); end
    checks++; if (ir[0] !== 32'h0C0A0B05) begin errors++; $display("FAIL nb_ir got %h required 0c0a0b05", ir[0]); end
    checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL nb_pending got %0d required 0", exp_q[0].size()); end
  endtask

  task automatic test_branch();
    int          tk[3] = '{0, 3, 0};
    logic [31:0] ta[3] = '{32'd3, 32'd9, 32'd9};
    logic [31:0] tb[3] = '{32'd7, 32'd9, 32'd9};
    logic [31:0] tm[3] = '{32'hFFFFFFFC, 32'd0, 32'd0};
    logic [7:0]  tp[3] = '{8'd5, 8'd5, 8'd1};
    bit to;
    for (int c = 0; c < 3; c++) begin
      clear_mem(tk[c]);
      mem[tk[c]][0] = 32'h0C0A0B05;
      mem[tk[c]][10] = ta[c];
      mem[tk[c]][11] = tb[c];
      set_lat(tk[c], 1, 2, 1);
      reset_core(tk[c]);
      exp_q[tk[c]].push_back({8'd12, tm[c]});
      run_prog(tk[c], 1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL br%0d_timeout got %b required 0", c, to); end
      checks++; if (mem[tk[c]][12] !== tm[c]) begin errors++; $display("FAIL br%0d_mem12 got %h required %h", c, mem[tk[c]][12], tm[c]); end
      checks++; if (pc[tk[c]] !== tp[c]) begin errors++; $display("FAIL br%0d_pc got %0d required %0d", c, pc[tk[c]], tp[c]); end
      checks++; if (exp_q[tk[c]].size() != 0) begin errors++; $display("FAIL br%0d_pending got %0d required 0", c, exp_q[tk[c]].size()); end
    end
  endtask

  task automatic test_handshake();
    bit to;
    logic [7:0] epc;
    int ecnt;
    set_lat(0, 1, 5, 2);
    for (int p = 0; p < 200; p++) begin
      for (int i = 0; i < 256; i++) mem[0][i] = $urandom();
      reset_core(0);
      ref_exec(0, 4, 1'b0, 255, epc, ecnt);
      run_prog(0, 4, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b required 0", p, to); end
      checks++; if (pc[0] !== epc) begin errors++; $display("FAIL rnd%0d_pc got %0d required %0d", p, pc[0], epc); end
      checks++; if (retired[0] !== 16'(ecnt)) begin errors++; $display("FAIL rnd%0d_retired got %0d required %0d", p, retired[0], ecnt); end
      checks++; if (halted[0] !== (epc == 8'd255)) begin errors++; $display("FAIL rnd%0d_halted got %b required %b", p, halted[0], epc == 8'd255); end
      checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL rnd%0d_pending got %0d required 0", p, exp_q[0].size()); exp_q[0].delete(); end
    end
  endtask

  task automatic test_run_toggle();
    int n0;
    bit hit, to;
    clear_mem(0);
    mem[0][0] = 32'h0C0A0B05;
    mem[0][1] = 32'h0D0A0B05;
    mem[0][10] = 32'd7;
    mem[0][11] = 32'd3;
    set_lat(0, 1, 1, 1);
    reset_core(0);
    exp_q[0].push_back({8'd12, 32'd4});
    exp_q[0].push_back({8'd13, 32'd4});
    n0 = nstart[0];
    run[0] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = nstart[0] == n0 + 3;
    end
    run[0] = 1'b0;
    checks++; if (hit !== 1'b1 || maddr[0] !== 8'd11) begin errors++; $display("FAIL rt_rd_s2 got addr=%0d hit=%b required addr=11 hit=1", maddr[0], hit); end
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = retired[0] == 16'd1;
    end
    repeat (30) @(negedge clk);
    checks++; if (retired[0] !== 16'd1) begin errors++; $display("FAIL rt_finish got %0d required 1", retired[0]); end
    checks++; if (nstart[0] != n0 + 4 || mstart[0] !== 1'b0) begin errors++; $display("FAIL rt_no_fetch got %0d starts required 4", nstart[0] - n0); end
    checks++; if (pc[0] !== 8'd1) begin errors++; $display("FAIL rt_pc got %0d required 1", pc[0]); end
    run_prog(0, 2, to);
    checks++; if (to !== 1'b0 || retired[0] !== 16'd2) begin errors++; $display("FAIL rt_resume got %0d required 2", retired[0]); end
    checks++; if (pc[0] !== 8'd2) begin errors++; $display("FAIL rt_pc2 got %0d required 2", pc[0]); end
    checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL rt_pending got %0d required 0", exp_q[0].size()); end
  endtask

  task automatic test_wrap();
    bit to;
    clear_mem(2);
    mem[2][0] = 32'h0C0A0BFF;
    mem[2][10] = 32'd3;
    mem[2][11] = 32'd7;
    mem[2][255] = 32'h0D0A0A00;
    set_lat(2, 1, 3, 2);
    reset_core(2);
    exp_q[2].push_back({8'd12, 32'hFFFFFFFC});
    exp_q[2].push_back({8'd13, 32'd0});
    run_prog(2, 2, to);
    checks++; if (to !== 1'b0 || retired[2] !== 16'd2) begin errors++; $display("FAIL wrap_retired got %0d required 2", retired[2]); end
    checks++; if (pc[2] !== 8'd0) begin errors++; $display("FAIL wrap_pc got %0d required 0", pc[2]); end
    checks++; if (halted[2] !== 1'b0) begin errors++; $display("FAIL wrap_halted got %b required 0", halted[2]); end
    checks++; if (exp_q[2].size() != 0) begin errors++; $display("FAIL wrap_pending got %0d required 0", exp_q[2].size()); end
  endtask

  task automatic test_alias();
    int         tk[2] = '{0, 3};
    logic [7:0] tp[2] = '{8'd1, 8'h30};
    bit to;
    for (int c = 0; c < 2; c++) begin
      clear_mem(tk[c]);
      mem[tk[c]][0] = 32'h14141430;
      mem[tk[c]][20] = 32'h55;
      set_lat(tk[c], 1, 4, 2);
      reset_core(tk[c]);
      exp_q[tk[c]].push_back({8'd20, 32'd0});
      run_prog(tk[c], 1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL al%0d_timeout got %b required 0", c, to); end
      checks++; if (mem[tk[c]][20] !== 32'd0) begin errors++; $display("FAIL al%0d_mem20 got %h required 0", c, mem[tk[c]][20]); end
      checks++; if (pc[tk[c]] !== tp[c]) begin errors++; $display("FAIL al%0d_pc got %h required %h", c, pc[tk[c]], tp[c]); end
      checks++; if (exp_q[tk[c]].size() != 0) begin errors++; $display("FAIL al%0d_pending got %0d required 0", c, exp_q[tk[c]].size()); end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rn[k] = 1'b0;
      run[k] = 1'b0;
      nstart[k] = 0;
      set_lat(k, 1, 1, 1);
      clear_mem(k);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rn[k] = 1'b1;
    test_reset();
    test_halt();
    test_nonbranch();
    test_branch();
    test_alias();
    test_run_toggle();
    test_wrap();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
